// File: rtl/pong_pkg.sv
// Shared definitions for the pong match controller and the display logic.
package pong_pkg;

  // State codes double as the curS debug value seen by the display block.
  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StMovL = 3'd1,
    StMovR = 3'd2,
    StPtL  = 3'd3,
    StPtR  = 3'd4,
    StOver = 3'd5
  } state_e;

  // True while a ball is in flight and the prescaler should run.
  function automatic logic is_moving(state_e s);
    return (s == StMovL) || (s == StMovR);
  endfunction

endpackage

// File: rtl/pong_tick_div.sv
// Ball-speed prescaler: one tick every TICK_DIV enabled cycles, restartable via clr_i.
module pong_tick_div #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk,
  input  logic ireset,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i & (cnt_q == CntMax);

  // Wrap at CntMax while enabled; a clear restarts the step period.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (ireset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pong_match_controller.sv
// Full pong match: serve, rally, miss/fault, scoring and game over on a one-hot LED court.
module pong_match_controller
  import pong_pkg::*;
#(
  parameter int unsigned COURT_W   = 8,
  parameter int unsigned TICK_DIV  = 4,
  parameter int unsigned SCORE_W   = 4,
  parameter int unsigned WIN_SCORE = 9
) (
  input  logic               clk,
  input  logic               ireset,
  input  logic               irsrv,
  input  logic               ilsrv,
  input  logic               irpad,
  input  logic               ilpad,
  output logic [COURT_W-1:0] court,
  output logic [SCORE_W-1:0] lscore,
  output logic [SCORE_W-1:0] rscore,
  output logic               lct,
  output logic               rct,
  output logic               game_over,
  output logic               winner,
  output logic [2:0]         curS
);

  localparam logic [SCORE_W-1:0] WinScore = SCORE_W'(WIN_SCORE);

  state_e             state_q, state_d;
  logic [COURT_W-1:0] court_q, court_d;
  logic [SCORE_W-1:0] lscore_q, lscore_d, rscore_q, rscore_d;
  logic               winner_q, winner_d;
  logic [1:0]         perm_q, perm_d;  // [1] right may serve, [0] left may serve
  logic               rsrv_prev_q, lsrv_prev_q;
  logic               rsrv_fall, lsrv_fall, tick, serve_clr;

  assign rsrv_fall = rsrv_prev_q & ~irsrv;
  assign lsrv_fall = lsrv_prev_q & ~ilsrv;

  pong_tick_div #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_div (
    .clk   (clk),
    .ireset(ireset),
    .clr_i (serve_clr),
    .en_i  (is_moving(state_q)),
    .tick_o(tick)
  );

  // Match FSM: serve acceptance, ball stepping, paddle decisions and scoring.
  always_comb begin
    state_d   = state_q;
    court_d   = court_q;
    lscore_d  = lscore_q;
    rscore_d  = rscore_q;
    winner_d  = winner_q;
    perm_d    = perm_q;
    serve_clr = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Right has priority on a simultaneous serve.
        if (rsrv_fall && perm_q[1]) begin
          state_d   = StMovL;
          court_d   = {1'b1, {(COURT_W-1){1'b0}}};
          serve_clr = 1'b1;
        end else if (lsrv_fall && perm_q[0]) begin
          state_d   = StMovR;
          court_d   = {{(COURT_W-1){1'b0}}, 1'b1};
          serve_clr = 1'b1;
        end
      end
      StMovL: begin
        if (tick) begin
          if (court_q[0] && !ilpad) begin
            state_d = StMovR;
            court_d = court_q << 1;
          end else if (court_q[0] || !ilpad) begin
            // Miss at the end, or a swing before the ball arrived.
            state_d = StPtR;
            court_d = '0;
            if (rscore_q != WinScore) rscore_d = rscore_q + 1'b1;
          end else begin
            court_d = court_q >> 1;
          end
        end
      end
      StMovR: begin
        if (tick) begin
          if (court_q[COURT_W-1] && !irpad) begin
            state_d = StMovL;
            court_d = court_q >> 1;
          end else if (court_q[COURT_W-1] || !irpad) begin
            state_d = StPtL;
            court_d = '0;
            if (lscore_q != WinScore) lscore_d = lscore_q + 1'b1;
          end else begin
            court_d = court_q << 1;
          end
        end
      end
      StPtL: begin
        perm_d = 2'b10;
        if (lscore_q == WinScore) begin
          state_d  = StOver;
          winner_d = 1'b0;
          court_d  = '1;
        end else begin
          state_d = StIdle;
        end
      end
      StPtR: begin
        perm_d = 2'b01;
        if (rscore_q == WinScore) begin
          state_d  = StOver;
          winner_d = 1'b1;
          court_d  = '1;
        end else begin
          state_d = StIdle;
        end
      end
      StOver: ;
      default: state_d = StIdle;
    endcase
  end

  // State, court, scores and serve-edge history; reset overrides everything.
  always_ff @(posedge clk) begin
    if (ireset) begin
      state_q     <= StIdle;
      court_q     <= '0;
      lscore_q    <= '0;
      rscore_q    <= '0;
      winner_q    <= 1'b0;
      perm_q      <= 2'b11;
      rsrv_prev_q <= 1'b1;
      lsrv_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      court_q     <= court_d;
      lscore_q    <= lscore_d;
      rscore_q    <= rscore_d;
      winner_q    <= winner_d;
      perm_q      <= perm_d;
      rsrv_prev_q <= irsrv;
      lsrv_prev_q <= ilsrv;
    end
  end

  assign court     = court_q;
  assign lscore    = lscore_q;
  assign rscore    = rscore_q;
  assign lct       = (state_q == StPtL);
  assign rct       = (state_q == StPtR);
  assign game_over = (state_q == StOver);
  assign winner    = winner_q;
  assign curS      = state_q;

endmodule
